// File: rtl/debug_pkg.sv
// Shared types and field layout for the debug change-monitor record path.
package debug_pkg;

  localparam int REC_WIDTH     = 192;
  localparam int LINE_CNT_BITS = 8;

  // Status word field offsets
  localparam int DONE_BIT      = 0;
  localparam int REC_TOTAL_LSB = 64;
  localparam int LINES_LSB     = 128;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    STATUS,
    DONE
  } packer_state_t;

  // Records that fit in a line once the top byte is reserved for the record count.
  function automatic int recs_per_line(input int data_w, input int rec_w);
    return (data_w - LINE_CNT_BITS) / rec_w;
  endfunction

endpackage

// File: rtl/debug_record_packer_if.sv
// Record FIFO read port plus memory write channel seen by the record packer.
interface debug_record_packer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int REC_WIDTH  = debug_pkg::REC_WIDTH
);
  import debug_pkg::*;

  logic                  rec_empty;
  logic                  rec_re;
  logic                  rec_valid;
  logic [REC_WIDTH-1:0]  rec_data;

  logic                  wr_available;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  rec_empty, rec_valid, rec_data, wr_available,
    output rec_re, req_wr, wr_addr, wr_data
  );

  modport slave (
    output rec_empty, rec_valid, rec_data, wr_available,
    input  rec_re, req_wr, wr_addr, wr_data
  );

endinterface

// File: rtl/debug_record_packer.sv
// Packs upstream debug records into memory lines, then writes a closing status word.
// Latency: the last record of a full line reaches wr_data 2 cycles after its rec_valid.
// Backpressure: no FIFO read while the line is full or a write waits on wr_available.
module debug_record_packer #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int REC_WIDTH  = debug_pkg::REC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  capture_done,
  input  logic [ADDR_WIDTH-1:0] output_address_in,
  input  logic [ADDR_WIDTH-1:0] status_address_in,
  debug_record_packer_if.master bus,
  output logic [ADDR_WIDTH-1:0] lines_written,
  output logic                  done
);
  import debug_pkg::*;

  localparam int RECS_PER_LINE = recs_per_line(DATA_WIDTH, REC_WIDTH);
  localparam int BUF_WIDTH     = RECS_PER_LINE * REC_WIDTH;
  localparam logic [LINE_CNT_BITS-1:0] SLOT_FULL = LINE_CNT_BITS'(RECS_PER_LINE);

  packer_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]    line_addr_q, line_addr_d;
  logic [ADDR_WIDTH-1:0]    status_addr_q, status_addr_d;
  logic [ADDR_WIDTH-1:0]    rec_total_q, rec_total_d;
  logic [ADDR_WIDTH-1:0]    lines_q, lines_d;
  logic [LINE_CNT_BITS-1:0] slot_q, slot_d;
  logic [BUF_WIDTH-1:0]     line_buf_q, line_buf_d;
  logic                     rd_pend_q, rd_pend_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic                     rec_re_c;
  logic [DATA_WIDTH-1:0]    line_word;
  logic [DATA_WIDTH-1:0]    status_word;

  always_comb begin
    line_word = '0;
    line_word[BUF_WIDTH-1:0] = line_buf_q;
    line_word[DATA_WIDTH-1 -: LINE_CNT_BITS] = slot_q;
    status_word = '0;
    status_word[DONE_BIT] = 1'b1;
    status_word[REC_TOTAL_LSB +: ADDR_WIDTH] = rec_total_q;
    status_word[LINES_LSB +: ADDR_WIDTH]     = lines_q;
  end

  always_comb begin
    state_d       = state_q;
    line_addr_d   = line_addr_q;
    status_addr_d = status_addr_q;
    rec_total_d   = rec_total_q;
    lines_d       = lines_q;
    slot_d        = slot_q;
    line_buf_d    = line_buf_q;
    rd_pend_d     = rd_pend_q;
    flush_pend_d  = flush_pend_q;
    req_wr_d      = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rec_re_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          line_addr_d   = output_address_in;
          status_addr_d = status_address_in;
          rec_total_d   = '0;
          lines_d       = '0;
          slot_d        = '0;
          line_buf_d    = '0;
          rd_pend_d     = 1'b0;
          flush_pend_d  = 1'b0;
          state_d       = FILL;
        end
      end
      FILL: begin
        rec_re_c = !bus.rec_empty && (slot_q < SLOT_FULL) && !rd_pend_q;
        if (rec_re_c) begin
          rd_pend_d = 1'b1;
        end
        if (bus.rec_valid) begin
          rd_pend_d = 1'b0;
          for (int i = 0; i < RECS_PER_LINE; i++) begin
            if (slot_q == LINE_CNT_BITS'(i)) begin
              line_buf_d[i*REC_WIDTH +: REC_WIDTH] = bus.rec_data;
            end
          end
          slot_d      = slot_q + LINE_CNT_BITS'(1);
          rec_total_d = rec_total_q + ADDR_WIDTH'(1);
        end
        // Jumping on the filling record itself keeps full-line latency at two cycles.
        if (slot_d == SLOT_FULL) begin
          state_d = ISSUE;
        end else if (flush_pend_q && bus.rec_empty && !rd_pend_q) begin
          state_d = (slot_q != '0) ? ISSUE : STATUS;
        end
      end
      ISSUE: begin
        if (bus.wr_available) begin
          req_wr_d    = 1'b1;
          wr_addr_d   = line_addr_q;
          wr_data_d   = line_word;
          line_addr_d = line_addr_q + ADDR_WIDTH'(1);
          lines_d     = lines_q + ADDR_WIDTH'(1);
          slot_d      = '0;
          line_buf_d  = '0;
          state_d     = FILL;
        end
      end
      STATUS: begin
        if (bus.wr_available) begin
          req_wr_d  = 1'b1;
          wr_addr_d = status_addr_q;
          wr_data_d = status_word;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture_done && (state_q != IDLE) && (state_q != DONE)) begin
      flush_pend_d = 1'b1;
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      line_addr_q   <= '0;
      status_addr_q <= '0;
      rec_total_q   <= '0;
      lines_q       <= '0;
      slot_q        <= '0;
      line_buf_q    <= '0;
      rd_pend_q     <= 1'b0;
      flush_pend_q  <= 1'b0;
      req_wr_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_addr_q   <= line_addr_d;
      status_addr_q <= status_addr_d;
      rec_total_q   <= rec_total_d;
      lines_q       <= lines_d;
      slot_q        <= slot_d;
      line_buf_q    <= line_buf_d;
      rd_pend_q     <= rd_pend_d;
      flush_pend_q  <= flush_pend_d;
      req_wr_q      <= req_wr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
    end
  end

  assign bus.rec_re     = rec_re_c;
  assign bus.req_wr     = req_wr_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign lines_written  = lines_q;
  assign done           = done_q;

endmodule

// File: tb/tb_debug_record_packer.sv
// Directed bench for debug_record_packer with a behavioural upstream FIFO and write log.
module tb_debug_record_packer;
  import debug_pkg::*;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int RW = 192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          capture_done = 1'b0;
  logic [AW-1:0] output_address_in = '0;
  logic [AW-1:0] status_address_in = '0;
  logic [AW-1:0] lines_written;
  logic          done;

  debug_record_packer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REC_WIDTH(RW)) bus ();

  debug_record_packer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REC_WIDTH(RW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .capture_done      (capture_done),
    .output_address_in (output_address_in),
    .status_address_in (status_address_in),
    .bus               (bus),
    .lines_written     (lines_written),
    .done              (done)
  );

  initial forever #5 clk = ~clk;

  logic [RW-1:0] fifo_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            vcyc_q[$];
  int            wcyc_q[$];
  int            cyc = 0;
  int            re_cnt = 0;
  int            wr_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Upstream FIFO: dout valid one cycle after a sampled read enable.
  initial begin
    bit take;
    take = 1'b0;
    bus.rec_empty = 1'b1;
    bus.rec_valid = 1'b0;
    bus.rec_data = '0;
    bus.wr_available = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        fifo_q.delete();
        take = 1'b0;
        bus.rec_valid = 1'b0;
        bus.rec_data = '0;
      end else if (take && fifo_q.size() > 0) begin
        bus.rec_valid = 1'b1;
        bus.rec_data = fifo_q.pop_front();
      end else begin
        bus.rec_valid = 1'b0;
      end
      bus.rec_empty = (fifo_q.size() == 0);
      #3;
      take = !rst && (bus.rec_re === 1'b1);
    end
  end

  initial forever begin
    @(negedge clk);
    #4;
    if (bus.rec_re === 1'b1) re_cnt = re_cnt + 1;
    if (bus.rec_valid) vcyc_q.push_back(cyc);
    if (bus.req_wr === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wcyc_q.push_back(cyc);
    end
  end

  function automatic logic [RW-1:0] mk_rec(input int id);
    logic [63:0] k;
    k = 64'(id);
    return {k + 64'h1000, 64'hA5A5_0000_0000_0000 | k, 64'h0123_4567_0000_0000 + (k << 4)};
  endfunction

  function automatic logic [DW-1:0] mk_line(input int cnt, input logic [RW-1:0] r0,
                                            input logic [RW-1:0] r1);
    logic [DW-1:0] l;
    l = '0;
    l[RW-1:0] = r0;
    l[2*RW-1:RW] = r1;
    l[DW-1 -: 8] = 8'(cnt);
    return l;
  endfunction

  function automatic logic [DW-1:0] mk_status(input int total, input int lines);
    logic [DW-1:0] l;
    l = '0;
    l[0] = 1'b1;
    l[127:64] = 64'(total);
    l[191:128] = 64'(lines);
    return l;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    vcyc_q.delete();
    wcyc_q.delete();
    re_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic do_reset();
    tick(1);
    rst = 1'b1;
    start = 1'b0;
    capture_done = 1'b0;
    bus.wr_available = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic begin_capture(input logic [AW-1:0] base, input logic [AW-1:0] stat);
    output_address_in = base;
    status_address_in = stat;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_capture_done();
    capture_done = 1'b1;
    tick(1);
    capture_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    fifo_q.push_back(mk_rec(99));
    tick(4);
    checks++; if (bus.req_wr !== 1'b0) begin errors++; $display("FAIL reset_req_wr got %b exp 0", bus.req_wr); end
    checks++; if (re_cnt !== 0) begin errors++; $display("FAIL reset_idle_rec_re got %0d exp 0", re_cnt); end
    checks++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", bus.wr_data); end
    checks++; if (lines_written !== '0) begin errors++; $display("FAIL reset_lines got %h exp 0", lines_written); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  task automatic test_full_lines();
    bit ok;
    logic [DW-1:0] exp;
    do_reset();
    begin_capture(64'h1000, 64'h2000);
    for (int i = 1; i <= 4; i++) fifo_q.push_back(mk_rec(i));
    tick(14);
    pulse_capture_done();
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout got done=%b exp 1", done); end
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL full_wr_count got %0d exp 3", wr_cnt); end
    checks++; if (wa_q[0] !== 64'h1000) begin errors++; $display("FAIL full_addr0 got %h exp 1000", wa_q[0]); end
    exp = mk_line(2, mk_rec(1), mk_rec(2));
    checks++; if (wd_q[0] !== exp) begin errors++; $display("FAIL full_line0 got %h exp %h", wd_q[0], exp); end
    checks++; if (wa_q[1] !== 64'h1001) begin errors++; $display("FAIL full_addr1 got %h exp 1001", wa_q[1]); end
    exp = mk_line(2, mk_rec(3), mk_rec(4));
    checks++; if (wd_q[1] !== exp) begin errors++; $display("FAIL full_line1 got %h exp %h", wd_q[1], exp); end
    checks++; if (wa_q[2] !== 64'h2000) begin errors++; $display("FAIL full_status_addr got %h exp 2000", wa_q[2]); end
    exp = mk_status(4, 2);
    checks++; if (wd_q[2] !== exp) begin errors++; $display("FAIL full_status got %h exp %h", wd_q[2], exp); end
    checks++; if (lines_written !== 64'd2) begin errors++; $display("FAIL full_lines got %0d exp 2", lines_written); end
    checks++; if (wcyc_q[0] - vcyc_q[1] !== 2) begin errors++; $display("FAIL full_latency0 got %0d exp 2", wcyc_q[0] - vcyc_q[1]); end
    checks++; if (wcyc_q[1] - vcyc_q[3] !== 2) begin errors++; $display("FAIL full_latency1 got %0d exp 2", wcyc_q[1] - vcyc_q[3]); end
  endtask

  task automatic test_partial_line();
    bit ok;
    logic [DW-1:0] exp;
    do_reset();
    begin_capture(64'h1000, 64'h2000);
    for (int i = 1; i <= 3; i++) fifo_q.push_back(mk_rec(i));
    tick(3);
    pulse_capture_done();
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL part_done_timeout got done=%b exp 1", done); end
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL part_wr_count got %0d exp 3", wr_cnt); end
    checks++; if (wa_q[1] !== 64'h1001) begin errors++; $display("FAIL part_addr1 got %h exp 1001", wa_q[1]); end
    exp = mk_line(1, mk_rec(3), '0);
    checks++; if (wd_q[1] !== exp) begin errors++; $display("FAIL part_line1 got %h exp %h", wd_q[1], exp); end
    exp = mk_status(3, 2);
    checks++; if (wd_q[2] !== exp) begin errors++; $display("FAIL part_status got %h exp %h", wd_q[2], exp); end
  endtask

  task automatic test_empty_capture();
    bit ok;
    logic [DW-1:0] exp;
    do_reset();
    begin_capture(64'h1000, 64'h2000);
    tick(3);
    pulse_capture_done();
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_done_timeout got done=%b exp 1", done); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL empty_wr_count got %0d exp 1", wr_cnt); end
    checks++; if (wa_q[0] !== 64'h2000) begin errors++; $display("FAIL empty_status_addr got %h exp 2000", wa_q[0]); end
    exp = mk_status(0, 0);
    checks++; if (wd_q[0] !== exp) begin errors++; $display("FAIL empty_status got %h exp %h", wd_q[0], exp); end
    checks++; if (re_cnt !== 0) begin errors++; $display("FAIL empty_reads got %0d exp 0", re_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW-1:0] exp;
    do_reset();
    bus.wr_available = 1'b0;
    for (int i = 0; i < 7; i++) fifo_q.push_back(mk_rec(16 + i));
    begin_capture(64'h1000, 64'h2000);
    tick(10);
    checks++; if (fifo_q.size() !== 5) begin errors++; $display("FAIL bp_fifo_level got %0d exp 5", fifo_q.size()); end
    tick(20);
    checks++; if (re_cnt !== 2) begin errors++; $display("FAIL bp_stall_reads got %0d exp 2", re_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL bp_stall_writes got %0d exp 0", wr_cnt); end
    bus.wr_available = 1'b1;
    pulse_capture_done();
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got done=%b exp 1", done); end
    checks++; if (wr_cnt !== 5) begin errors++; $display("FAIL bp_wr_count got %0d exp 5", wr_cnt); end
    for (int i = 0; i < 3; i++) begin
      exp = mk_line(2, mk_rec(16 + 2*i), mk_rec(17 + 2*i));
      checks++; if (wd_q[i] !== exp) begin errors++; $display("FAIL bp_line%0d got %h exp %h", i, wd_q[i], exp); end
      checks++; if (wa_q[i] !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL bp_addr%0d got %h exp %h", i, wa_q[i], 64'h1000 + 64'(i)); end
    end
    exp = mk_line(1, mk_rec(22), '0);
    checks++; if (wd_q[3] !== exp) begin errors++; $display("FAIL bp_line3 got %h exp %h", wd_q[3], exp); end
    exp = mk_status(7, 4);
    checks++; if (wd_q[4] !== exp) begin errors++; $display("FAIL bp_status got %h exp %h", wd_q[4], exp); end
  endtask

  task automatic test_capture_with_valid();
    bit ok;
    bit found;
    int vcnt;
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 1; i <= 3; i++) fifo_q.push_back(mk_rec(40 + i));
    begin_capture(64'h1000, 64'h2000);
    found = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (bus.rec_valid) begin
        vcnt++;
        if (vcnt == 3) begin
          capture_done = 1'b1;
          found = 1'b1;
        end
      end
    end
    tick(1);
    capture_done = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL cv_third_valid got %0d valids exp 3", vcnt); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cv_done_timeout got done=%b exp 1", done); end
    checks++; if (wa_q[1] !== 64'h1001) begin errors++; $display("FAIL cv_addr1 got %h exp 1001", wa_q[1]); end
    exp = mk_line(1, mk_rec(43), '0);
    checks++; if (wd_q[1] !== exp) begin errors++; $display("FAIL cv_line1 got %h exp %h", wd_q[1], exp); end
    exp = mk_status(3, 2);
    checks++; if (wd_q[2] !== exp) begin errors++; $display("FAIL cv_status got %h exp %h", wd_q[2], exp); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    bit seen;
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(mk_rec(60 + i));
    begin_capture(64'h1000, 64'h2000);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (wr_cnt == 1) begin
        bus.wr_available = 1'b0;
        seen = 1'b1;
      end
    end
    tick(10);
    checks++; if (!seen) begin errors++; $display("FAIL rm_first_write got %0d writes exp 1", wr_cnt); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL rm_stalled got %0d writes exp 1", wr_cnt); end
    checks++; if (lines_written !== 64'd1) begin errors++; $display("FAIL rm_pre_lines got %0d exp 1", lines_written); end
    rst = 1'b1;
    tick(1);
    checks++; if (bus.req_wr !== 1'b0) begin errors++; $display("FAIL rm_req_wr got %b exp 0", bus.req_wr); end
    checks++; if (bus.rec_re !== 1'b0) begin errors++; $display("FAIL rm_rec_re got %b exp 0", bus.rec_re); end
    checks++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL rm_wr_addr got %h exp 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== '0) begin errors++; $display("FAIL rm_wr_data got %h exp 0", bus.wr_data); end
    checks++; if (lines_written !== '0) begin errors++; $display("FAIL rm_lines got %0d exp 0", lines_written); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done got %b exp 0", done); end
    rst = 1'b0;
    bus.wr_available = 1'b1;
    tick(1);
    clear_logs();
    fifo_q.push_back(mk_rec(70));
    fifo_q.push_back(mk_rec(71));
    begin_capture(64'h3000, 64'h4000);
    tick(3);
    pulse_capture_done();
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_restart_timeout got done=%b exp 1", done); end
    checks++; if (wa_q[0] !== 64'h3000) begin errors++; $display("FAIL rm_restart_addr got %h exp 3000", wa_q[0]); end
    exp = mk_line(2, mk_rec(70), mk_rec(71));
    checks++; if (wd_q[0] !== exp) begin errors++; $display("FAIL rm_restart_line got %h exp %h", wd_q[0], exp); end
    exp = mk_status(2, 1);
    checks++; if (wd_q[1] !== exp) begin errors++; $display("FAIL rm_restart_status got %h exp %h", wd_q[1], exp); end
    checks++; if (lines_written !== 64'd1) begin errors++; $display("FAIL rm_restart_lines got %0d exp 1", lines_written); end
  endtask

  initial begin
    test_reset();
    test_full_lines();
    test_partial_line();
    test_empty_capture();
    test_backpressure();
    test_capture_with_valid();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
